// File: rtl/pipe_pkg.sv
// Shared definitions for handshaked inter-stage registers: WB control bit
// positions and the stage occupancy state encoding.
package pipe_pkg;

   localparam int WB_JAL    = 0;
   localparam int WB_LB     = 1;
   localparam int WB_FPW    = 2;
   localparam int WB_HILO   = 3;
   localparam int WB_MULDIV = 4;
   localparam int WB_FLOAT  = 5;
   localparam int WB_M2R64  = 6;
   localparam int WB_M2R    = 7;
   localparam int WB_REGW   = 8;
   localparam int WB_W3264  = 9;
   localparam int WB_CTRL_W = 10;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One beat of storage: valid + ctrl + data. Clearing drops valid and zeroes
// ctrl (bubble = NOP) but leaves data untouched.
module pipe_stage_slot #(
   parameter int CTRL_W = 10,
   parameter int DATA_W = 192
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              load,
   input  logic              clr,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (clr) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= d_ctrl;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         data <= '0;
      else if (load && !clr)
         data <= d_data;
   end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline-stage register with flush. SKID_EN=1 adds a second
// entry so in_ready can come straight from a flop.
module pipe_stage_hs
   import pipe_pkg::*;
#(
   parameter int DATA_W  = 192,
   parameter int CTRL_W  = WB_CTRL_W,
   parameter int SKID_EN = 1
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   pipe_state_t       state, state_n;
   logic              accept, xfer;
   logic              main_ld, main_clr, main_from_skid;
   logic              skid_ld, skid_clr;
   logic              main_v, skid_v;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
   logic [DATA_W-1:0] main_data, skid_data, main_d_data;

   assign accept = in_valid && in_ready;
   assign xfer   = main_v && out_ready;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         state <= EMPTY;
      else
         state <= state_n;
   end

   always_comb begin
      state_n        = state;
      main_ld        = 1'b0;
      main_clr       = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      skid_clr       = 1'b0;
      if (flush) begin
         // A beat accepted this cycle is dropped; a transfer still happened.
         state_n  = EMPTY;
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_ld = 1'b1;
                  state_n = ONE;
               end
            end
            ONE: begin
               if (accept && xfer) begin
                  main_ld = 1'b1;
               end else if (accept) begin
                  // Only reachable with the skid entry; without it in_ready
                  // implies out_ready whenever MAIN is valid.
                  if (SKID_EN != 0) begin
                     skid_ld = 1'b1;
                     state_n = FULL;
                  end
               end else if (xfer) begin
                  main_clr = 1'b1;
                  state_n  = EMPTY;
               end
            end
            FULL: begin
               if (xfer) begin
                  main_ld        = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clr       = 1'b1;
                  state_n        = ONE;
               end
            end
            default: state_n = EMPTY;
         endcase
      end
   end

   assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
   assign main_d_data = main_from_skid ? skid_data : in_data;

   pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .Clk    (Clk),
      .Rst    (Rst),
      .load   (main_ld),
      .clr    (main_clr),
      .d_ctrl (main_d_ctrl),
      .d_data (main_d_data),
      .valid  (main_v),
      .ctrl   (main_ctrl),
      .data   (main_data)
   );

   generate
      if (SKID_EN != 0) begin : g_skid
         logic rdy_q;

         pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .Clk    (Clk),
            .Rst    (Rst),
            .load   (skid_ld),
            .clr    (skid_clr),
            .d_ctrl (in_ctrl),
            .d_data (in_data),
            .valid  (skid_v),
            .ctrl   (skid_ctrl),
            .data   (skid_data)
         );

         // Registered ready: low exactly while the stage holds two beats.
         always_ff @(posedge Clk or posedge Rst) begin
            if (Rst)
               rdy_q <= 1'b1;
            else
               rdy_q <= (state_n != FULL);
         end

         assign in_ready = rdy_q;
      end else begin : g_noskid
         logic unused_skid;

         assign skid_v      = 1'b0;
         assign skid_ctrl   = '0;
         assign skid_data   = '0;
         assign unused_skid = skid_ld | skid_clr;
         assign in_ready    = !main_v || out_ready;
      end
   endgenerate

   assign out_valid = main_v;
   assign out_ctrl  = main_ctrl;
   assign out_data  = main_data;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: skid variant (a_*) and single-register
// variant (b_*) side by side, with hand-computed expectations.
module tb_pipe_stage_hs;

   localparam int DW = 192;
   localparam int CW = 10;
   localparam logic [DW-1:0] PAT = {24{8'hA5}};

   logic          Clk = 1'b0;
   logic          Rst;
   int            n_tests = 0;
   int            n_fail  = 0;

   logic          a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
   logic [CW-1:0] a_in_ctrl, a_out_ctrl;
   logic [DW-1:0] a_in_data, a_out_data;
   logic [1:0]    a_occ;

   logic          b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
   logic [CW-1:0] b_in_ctrl, b_out_ctrl;
   logic [DW-1:0] b_in_data, b_out_data;
   logic [1:0]    b_occ;

   always #5 Clk = ~Clk;

   pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1)) dut_a (
      .Clk(Clk), .Rst(Rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_ctrl(a_in_ctrl), .in_data(a_in_data), .flush(a_flush),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
      .out_data(a_out_data), .occupancy(a_occ)
   );

   pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0)) dut_b (
      .Clk(Clk), .Rst(Rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_ctrl(b_in_ctrl), .in_data(b_in_data), .flush(b_flush),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
      .out_data(b_out_data), .occupancy(b_occ)
   );

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic a_beat(input logic [CW-1:0] c, input logic [DW-1:0] d);
      a_in_valid = 1'b1;
      a_in_ctrl  = c;
      a_in_data  = d;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      a_in_valid = 0; a_in_ctrl = '0; a_in_data = '0; a_flush = 0; a_out_ready = 1;
      b_in_valid = 0; b_in_ctrl = '0; b_in_data = '0; b_flush = 0; b_out_ready = 1;
      @(negedge Clk);
      n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid got %b want 0", a_out_valid); end
      n_tests++; if (a_out_ctrl !== '0) begin n_fail++; $display("FAIL rst_a_ctrl got %h want 0", a_out_ctrl); end
      n_tests++; if (a_out_data !== '0) begin n_fail++; $display("FAIL rst_a_data got %h want 0", a_out_data); end
      n_tests++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL rst_a_occ got %0d want 0", a_occ); end
      n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_a_ready got %b want 1", a_in_ready); end
      n_tests++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_b_ready got %b want 1", b_in_ready); end
      n_tests++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid got %b want 0", b_out_valid); end
      step();
      Rst = 1'b0;
   endtask

   task automatic test_single();
      a_beat(10'h100, PAT);
      a_out_ready = 1'b1;
      step();
      a_in_valid = 1'b0;
      n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", a_out_valid); end
      n_tests++; if (a_out_ctrl !== 10'h100) begin n_fail++; $display("FAIL single_ctrl got %h want 100", a_out_ctrl); end
      n_tests++; if (a_out_data !== PAT) begin n_fail++; $display("FAIL single_data got %h want %h", a_out_data, PAT); end
      n_tests++; if (a_occ !== 2'd1) begin n_fail++; $display("FAIL single_occ got %0d want 1", a_occ); end
      step();
      n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_bubble_valid got %b want 0", a_out_valid); end
      n_tests++; if (a_out_ctrl !== '0) begin n_fail++; $display("FAIL single_bubble_ctrl got %h want 0", a_out_ctrl); end
      n_tests++; if (a_out_data !== PAT) begin n_fail++; $display("FAIL single_hold_data got %h want %h", a_out_data, PAT); end
      n_tests++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL single_bubble_occ got %0d want 0", a_occ); end
   endtask

   task automatic test_throughput();
      a_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_beat(CW'(i + 1), DW'(i));
         n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL thru_ready[%0d] got %b want 1", i, a_in_ready); end
         step();
         n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== DW'(i) || a_out_ctrl !== CW'(i + 1))
            begin n_fail++; $display("FAIL thru_out[%0d] got v=%b d=%0h c=%0h want v=1 d=%0h c=%0h", i, a_out_valid, a_out_data, a_out_ctrl, i, i + 1); end
      end
      a_in_valid = 1'b0;
      step();
      n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL thru_end_valid got %b want 0", a_out_valid); end
   endtask

   task automatic test_backpressure();
      a_out_ready = 1'b1;
      a_beat(10'h00A, DW'(10));
      step();
      a_out_ready = 1'b0;
      a_beat(10'h00B, DW'(11));
      step();
      n_tests++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ got %0d want 2", a_occ); end
      n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %b want 0", a_in_ready); end
      n_tests++; if (a_out_data !== DW'(10)) begin n_fail++; $display("FAIL bp_head got %0h want a", a_out_data); end
      a_beat(10'h00C, DW'(12));
      step();
      n_tests++; if (a_occ !== 2'd2 || a_out_data !== DW'(10)) begin n_fail++; $display("FAIL bp_hold got occ=%0d d=%0h want occ=2 d=a", a_occ, a_out_data); end
      a_out_ready = 1'b1;
      step();
      n_tests++; if (a_out_data !== DW'(11) || a_out_ctrl !== 10'h00B || a_occ !== 2'd1)
         begin n_fail++; $display("FAIL bp_drain1 got d=%0h c=%0h occ=%0d want d=b c=b occ=1", a_out_data, a_out_ctrl, a_occ); end
      n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got %b want 1", a_in_ready); end
      step();
      a_in_valid = 1'b0;
      n_tests++; if (a_out_data !== DW'(12) || a_out_valid !== 1'b1 || a_occ !== 2'd1)
         begin n_fail++; $display("FAIL bp_drain2 got d=%0h v=%b occ=%0d want d=c v=1 occ=1", a_out_data, a_out_valid, a_occ); end
      step();
      n_tests++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin n_fail++; $display("FAIL bp_empty got v=%b occ=%0d want v=0 occ=0", a_out_valid, a_occ); end
   endtask

   task automatic test_flush();
      a_out_ready = 1'b0;
      a_beat(10'h014, DW'(20));
      step();
      a_beat(10'h015, DW'(21));
      step();
      n_tests++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ got %0d want 2", a_occ); end
      a_beat(10'h3FF, DW'(22));
      a_flush = 1'b1;
      step();
      a_flush = 1'b0;
      a_in_valid = 1'b0;
      n_tests++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", a_occ); end
      n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", a_out_valid); end
      n_tests++; if (a_out_ctrl !== '0) begin n_fail++; $display("FAIL flush_ctrl got %h want 0", a_out_ctrl); end
      n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", a_in_ready); end
      a_out_ready = 1'b1;
      step();
      n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_absent got v=%b want 0", a_out_valid); end
      n_tests++; if (a_out_data !== DW'(20)) begin n_fail++; $display("FAIL flush_data_kept got %0h want 14", a_out_data); end
   endtask

   task automatic test_async_reset();
      a_out_ready = 1'b0;
      a_beat(10'h01E, DW'(30));
      step();
      a_beat(10'h01F, DW'(31));
      step();
      a_in_valid = 1'b0;
      n_tests++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL arst_pre_occ got %0d want 2", a_occ); end
      #2;
      Rst = 1'b1;
      #1;
      n_tests++; if (a_out_valid !== 1'b0 || a_out_ctrl !== '0 || a_out_data !== '0)
         begin n_fail++; $display("FAIL arst_out got v=%b c=%h d=%h want all 0", a_out_valid, a_out_ctrl, a_out_data); end
      n_tests++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL arst_occ got %0d want 0", a_occ); end
      n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready got %b want 1", a_in_ready); end
      #2;
      Rst = 1'b0;
      a_out_ready = 1'b1;
      step();
   endtask

   task automatic test_noskid();
      b_out_ready = 1'b0;
      b_in_valid = 1'b1; b_in_ctrl = 10'h028; b_in_data = DW'(40);
      step();
      b_in_valid = 1'b0;
      n_tests++; if (b_out_valid !== 1'b1 || b_out_data !== DW'(40)) begin n_fail++; $display("FAIL ns_load got v=%b d=%0h want v=1 d=28", b_out_valid, b_out_data); end
      n_tests++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL ns_ready_low got %b want 0", b_in_ready); end
      n_tests++; if (b_occ !== 2'd1) begin n_fail++; $display("FAIL ns_occ got %0d want 1", b_occ); end
      b_out_ready = 1'b1;
      b_in_valid = 1'b1; b_in_ctrl = 10'h029; b_in_data = DW'(41);
      #1;
      n_tests++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL ns_ready_comb got %b want 1", b_in_ready); end
      step();
      b_in_valid = 1'b0;
      n_tests++; if (b_out_valid !== 1'b1 || b_out_data !== DW'(41) || b_out_ctrl !== 10'h029 || b_occ !== 2'd1)
         begin n_fail++; $display("FAIL ns_reload got v=%b d=%0h c=%h occ=%0d want v=1 d=29 c=029 occ=1", b_out_valid, b_out_data, b_out_ctrl, b_occ); end
      step();
      n_tests++; if (b_out_valid !== 1'b0 || b_out_ctrl !== '0) begin n_fail++; $display("FAIL ns_drain got v=%b c=%h want 0 0", b_out_valid, b_out_ctrl); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_throughput();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_noskid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
